agex_branch_predictor: RTL and testbench

- Responder end of the FE/AGEX branch interface.
- Holds the global branch history register (BHR), the gshare pattern table (PT) of 2-bit counters, and the branch target buffer (BTB).
- Serves combinational fetch-time lookups to FE_STAGE.
- Accepts branch resolutions from the AGEX stage, updates all tables, and drives the registered redirect (br_cond, newpc) back to FE on a mispredict.

---
 rtl/agex_branch_predictor.sv | 220 ++++++++++++++++++++++
 tb/tb_agex_branch_predictor.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/agex_branch_predictor.sv
// agex_branch_predictor
//   Responder end of the FE/AGEX branch interface. Holds the global branch
//   history register (BHR), the gshare pattern table (PT) of 2-bit saturating
//   counters and the branch target buffer (BTB). Fetch lookups are purely
//   combinational; resolutions from AGEX update the tables at the next edge
//   and raise a registered one-cycle redirect (br_cond/newpc) on a mispredict.
//
// Ports
//   clk, reset          : clock, synchronous active-high reset
//   fe_pc               : fetch PC for the lookup
//   memaddr_pt/_btb     : lookup indices (gshare index, BTB index)
//   rd_val_*            : BHR, PT counter, BTB tag/target at the lookup index
//   btb_hit, pred_taken : lookup result (pred_taken forced 0 while busy)
//   res_*               : branch/jump resolution from AGEX
//   br_cond, newpc      : registered redirect to FE
//   busy                : table initialisation in progress
//   br_cnt, mispred_cnt : resolved branch/jump and mispredict counters
module agex_branch_predictor #(
  parameter int DBITS        = 32,
  parameter int PTINDEXBITS  = 8,
  parameter int BTBINDEXBITS = 4,
  parameter int TAGBITS      = DBITS - BTBINDEXBITS - 2
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [DBITS-1:0]        fe_pc,
  output logic [PTINDEXBITS-1:0]  memaddr_pt,
  output logic [BTBINDEXBITS-1:0] memaddr_btb,
  output logic [PTINDEXBITS-1:0]  rd_val_bhr,
  output logic [1:0]              rd_val_pt,
  output logic [TAGBITS-1:0]      rd_val_btb_tag,
  output logic [DBITS-1:0]        rd_val_btb_value,
  output logic                    btb_hit,
  output logic                    pred_taken,
  input  logic                    res_valid,
  input  logic                    res_is_br,
  input  logic                    res_is_jmp,
  input  logic [DBITS-1:0]        res_pc,
  input  logic [PTINDEXBITS-1:0]  res_pt_idx,
  input  logic                    res_pred_taken,
  input  logic [DBITS-1:0]        res_pred_target,
  input  logic                    res_taken,
  input  logic [DBITS-1:0]        res_target,
  output logic                    br_cond,
  output logic [DBITS-1:0]        newpc,
  output logic                    busy,
  output logic [31:0]             br_cnt,
  output logic [31:0]             mispred_cnt
);

  localparam int PT_DEPTH  = 1 << PTINDEXBITS;
  localparam int BTB_DEPTH = 1 << BTBINDEXBITS;
  // BTB depth expressed in the init counter's width (+1 so it cannot overflow)
  localparam logic [PTINDEXBITS:0] BTB_DEPTH_W = (PTINDEXBITS+1)'(BTB_DEPTH);

  typedef enum logic {ST_INIT, ST_RUN} state_t;

  state_t                   state_q, state_d;
  logic [PTINDEXBITS-1:0]   cnt_q, cnt_d;
  logic [PTINDEXBITS-1:0]   bhr_q, bhr_d;
  logic                     br_cond_q, br_cond_d;
  logic [DBITS-1:0]         newpc_q, newpc_d;
  logic [31:0]              br_cnt_q, br_cnt_d;
  logic [31:0]              mispred_cnt_q, mispred_cnt_d;

  // Tables: written through a single write port each, read combinationally
  logic [1:0]               pt_q        [PT_DEPTH];
  logic                     btb_valid_q [BTB_DEPTH];
  logic [TAGBITS-1:0]       btb_tag_q   [BTB_DEPTH];
  logic [DBITS-1:0]         btb_value_q [BTB_DEPTH];

  logic                     pt_we;
  logic [PTINDEXBITS-1:0]   pt_waddr;
  logic [1:0]               pt_wdata;
  logic [1:0]               pt_old;
  logic                     btb_we;
  logic [BTBINDEXBITS-1:0]  btb_waddr;
  logic                     btb_wvalid;
  logic [TAGBITS-1:0]       btb_wtag;
  logic [DBITS-1:0]         btb_wvalue;

  logic                     upd;
  logic                     mispred;

  // Low PC bits are always zero for aligned fetch; not part of any index
  logic                     unused_fe_pc_lsbs;
  assign unused_fe_pc_lsbs = ^fe_pc[1:0];

  // ------------------------------------------------------------------
  // Fetch-time lookup (reads the pre-update table contents)
  // ------------------------------------------------------------------
  assign memaddr_pt       = fe_pc[PTINDEXBITS+1:2] ^ bhr_q;
  assign memaddr_btb      = fe_pc[BTBINDEXBITS+1:2];
  assign rd_val_bhr       = bhr_q;
  assign rd_val_pt        = pt_q[memaddr_pt];
  assign rd_val_btb_tag   = btb_tag_q[memaddr_btb];
  assign rd_val_btb_value = btb_value_q[memaddr_btb];
  assign btb_hit          = btb_valid_q[memaddr_btb] &&
                            (btb_tag_q[memaddr_btb] == fe_pc[DBITS-1:BTBINDEXBITS+2]);
  assign busy             = (state_q == ST_INIT);
  assign pred_taken       = btb_hit & rd_val_pt[1] & ~busy;

  assign br_cond          = br_cond_q;
  assign newpc            = newpc_q;
  assign br_cnt           = br_cnt_q;
  assign mispred_cnt      = mispred_cnt_q;

  // ------------------------------------------------------------------
  // Resolution decode
  // ------------------------------------------------------------------
  assign upd     = (state_q == ST_RUN) & res_valid & (res_is_br | res_is_jmp);
  assign mispred = (res_pred_taken != res_taken) |
                   (res_taken & (res_pred_target != res_target));
  assign pt_old  = pt_q[res_pt_idx];

  // ------------------------------------------------------------------
  // Next-state / table write logic
  // ------------------------------------------------------------------
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    bhr_d         = bhr_q;
    br_cond_d     = 1'b0;
    newpc_d       = newpc_q;
    br_cnt_d      = br_cnt_q;
    mispred_cnt_d = mispred_cnt_q;
    pt_we         = 1'b0;
    pt_waddr      = '0;
    pt_wdata      = 2'b01;
    btb_we        = 1'b0;
    btb_waddr     = '0;
    btb_wvalid    = 1'b0;
    btb_wtag      = '0;
    btb_wvalue    = '0;

    if (state_q == ST_INIT) begin
      // Sweep every PT entry to weakly-not-taken; the BTB is smaller, so
      // only the first BTB_DEPTH steps of the sweep invalidate it.
      pt_we    = 1'b1;
      pt_waddr = cnt_q;
      pt_wdata = 2'b01;
      if ({1'b0, cnt_q} < BTB_DEPTH_W) begin
        btb_we    = 1'b1;
        btb_waddr = cnt_q[BTBINDEXBITS-1:0];
      end
      cnt_d = cnt_q + 1'b1;
      if (cnt_q == '1) begin
        state_d = ST_RUN;
      end
    end else if (upd) begin
      br_cnt_d = br_cnt_q + 32'd1;

      // A jump wins over the branch flag: only true branches train PT/BHR
      if (!res_is_jmp) begin
        pt_we    = 1'b1;
        pt_waddr = res_pt_idx;
        if (res_taken) begin
          pt_wdata = (pt_old == 2'b11) ? 2'b11 : pt_old + 2'd1;
        end else begin
          pt_wdata = (pt_old == 2'b00) ? 2'b00 : pt_old - 2'd1;
        end
        bhr_d = {bhr_q[PTINDEXBITS-2:0], res_taken};
      end

      if (res_taken) begin
        btb_we     = 1'b1;
        btb_waddr  = res_pc[BTBINDEXBITS+1:2];
        btb_wvalid = 1'b1;
        btb_wtag   = res_pc[DBITS-1:BTBINDEXBITS+2];
        btb_wvalue = res_target;
      end

      if (mispred) begin
        br_cond_d     = 1'b1;
        newpc_d       = res_taken ? res_target : res_pc + DBITS'(4);
        mispred_cnt_d = mispred_cnt_q + 32'd1;
      end
    end
  end

  // ------------------------------------------------------------------
  // State registers
  // ------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= ST_INIT;
      cnt_q         <= '0;
      bhr_q         <= '0;
      br_cond_q     <= 1'b0;
      newpc_q       <= '0;
      br_cnt_q      <= '0;
      mispred_cnt_q <= '0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      bhr_q         <= bhr_d;
      br_cond_q     <= br_cond_d;
      newpc_q       <= newpc_d;
      br_cnt_q      <= br_cnt_d;
      mispred_cnt_q <= mispred_cnt_d;
    end
  end

  // Table write ports; no writes on the reset cycle so a reset mid-run
  // cannot let a concurrent resolution slip into the tables.
  always_ff @(posedge clk) begin
    if (!reset && pt_we) begin
      pt_q[pt_waddr] <= pt_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset && btb_we) begin
      btb_valid_q[btb_waddr] <= btb_wvalid;
      btb_tag_q[btb_waddr]   <= btb_wtag;
      btb_value_q[btb_waddr] <= btb_wvalue;
    end
  end

endmodule

// File: tb/tb_agex_branch_predictor.sv
module tb_agex_branch_predictor;

  localparam int DB   = 32;
  localparam int PTB  = 8;
  localparam int BTBB = 4;
  localparam int TB   = DB - BTBB - 2;

  logic            clk;
  logic            reset;
  logic [DB-1:0]   fe_pc;
  logic [PTB-1:0]  memaddr_pt;
  logic [BTBB-1:0] memaddr_btb;
  logic [PTB-1:0]  rd_val_bhr;
  logic [1:0]      rd_val_pt;
  logic [TB-1:0]   rd_val_btb_tag;
  logic [DB-1:0]   rd_val_btb_value;
  logic            btb_hit;
  logic            pred_taken;
  logic            res_valid;
  logic            res_is_br;
  logic            res_is_jmp;
  logic [DB-1:0]   res_pc;
  logic [PTB-1:0]  res_pt_idx;
  logic            res_pred_taken;
  logic [DB-1:0]   res_pred_target;
  logic            res_taken;
  logic [DB-1:0]   res_target;
  logic            br_cond;
  logic [DB-1:0]   newpc;
  logic            busy;
  logic [31:0]     br_cnt;
  logic [31:0]     mispred_cnt;

  agex_branch_predictor #(
    .DBITS(DB), .PTINDEXBITS(PTB), .BTBINDEXBITS(BTBB)
  ) dut (
    .clk(clk), .reset(reset), .fe_pc(fe_pc),
    .memaddr_pt(memaddr_pt), .memaddr_btb(memaddr_btb),
    .rd_val_bhr(rd_val_bhr), .rd_val_pt(rd_val_pt),
    .rd_val_btb_tag(rd_val_btb_tag), .rd_val_btb_value(rd_val_btb_value),
    .btb_hit(btb_hit), .pred_taken(pred_taken),
    .res_valid(res_valid), .res_is_br(res_is_br), .res_is_jmp(res_is_jmp),
    .res_pc(res_pc), .res_pt_idx(res_pt_idx), .res_pred_taken(res_pred_taken),
    .res_pred_target(res_pred_target), .res_taken(res_taken),
    .res_target(res_target), .br_cond(br_cond), .newpc(newpc), .busy(busy),
    .br_cnt(br_cnt), .mispred_cnt(mispred_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end else begin
      $display("ok   %s: 0x%08h", tag, got);
    end
  endtask

  // ---------------- reference model ----------------
  logic [1:0]    pt_m    [256];
  logic          btb_v_m [16];
  logic [TB-1:0] btb_t_m [16];
  logic [DB-1:0] btb_d_m [16];
  logic [7:0]    bhr_m;
  logic [31:0]   newpc_m, brc_m, misc_m;
  bit            busy_m;

  typedef struct {
    logic        cond;
    logic [31:0] pc;
  } exp_t;
  exp_t exp_q[$];

  task automatic model_reset();
    for (int i = 0; i < 256; i++) pt_m[i] = 2'b01;
    for (int i = 0; i < 16; i++) begin
      btb_v_m[i] = 1'b0;
      btb_t_m[i] = '0;
      btb_d_m[i] = '0;
    end
    bhr_m   = '0;
    newpc_m = '0;
    brc_m   = '0;
    misc_m  = '0;
    busy_m  = 1'b1;
  endtask

  task automatic pop_check(input string tag);
    exp_t e;
    if (exp_q.size() == 0) begin
      check_val({tag, "_queue_empty"}, 32'd0, 32'd1);
    end else begin
      e = exp_q.pop_front();
      check_val({tag, "_br_cond"}, {31'd0, br_cond}, {31'd0, e.cond});
      check_val({tag, "_newpc"}, newpc, e.pc);
    end
  endtask

  task automatic idle_cycle(input string tag);
    exp_t e;
    e.cond = 1'b0;
    e.pc   = newpc_m;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    pop_check(tag);
  endtask

  task automatic resolve(input logic br, input logic jmp, input logic [31:0] pc,
                         input logic [7:0] idx, input logic ptk, input logic [31:0] ptgt,
                         input logic tk, input logic [31:0] tgt, input string tag);
    exp_t e;
    logic upd, mis;
    logic [7:0] look_idx;
    res_valid = 1'b1; res_is_br = br; res_is_jmp = jmp; res_pc = pc;
    res_pt_idx = idx; res_pred_taken = ptk; res_pred_target = ptgt;
    res_taken = tk; res_target = tgt;
    upd = !busy_m && (br || jmp);
    mis = upd && ((ptk != tk) || (tk && (ptgt != tgt)));
    if (mis) newpc_m = tk ? tgt : pc + 32'd4;
    e.cond = mis;
    e.pc   = newpc_m;
    exp_q.push_back(e);
    #1;
    // Lookup before the edge must still see the old BHR / PT contents
    check_val({tag, "_bhr_pre"}, {24'd0, rd_val_bhr}, {24'd0, bhr_m});
    if (!busy_m) begin
      look_idx = fe_pc[9:2] ^ bhr_m;
      check_val({tag, "_pt_pre"}, {30'd0, rd_val_pt}, {30'd0, pt_m[look_idx]});
    end
    @(posedge clk);
    if (upd) begin
      brc_m++;
      if (mis) misc_m++;
      if (!jmp) begin
        if (tk) pt_m[idx] = (pt_m[idx] == 2'b11) ? 2'b11 : pt_m[idx] + 2'd1;
        else    pt_m[idx] = (pt_m[idx] == 2'b00) ? 2'b00 : pt_m[idx] - 2'd1;
        bhr_m = {bhr_m[6:0], tk};
      end
      if (tk) begin
        btb_v_m[pc[5:2]] = 1'b1;
        btb_t_m[pc[5:2]] = pc[31:6];
        btb_d_m[pc[5:2]] = tgt;
      end
    end
    #1;
    res_valid = 1'b0;
    pop_check(tag);
    check_val({tag, "_br_cnt"}, br_cnt, brc_m);
    check_val({tag, "_mispred_cnt"}, mispred_cnt, misc_m);
  endtask

  task automatic lookup_chk(input logic [31:0] pc, input string tag);
    logic [7:0] idx;
    logic [3:0] bi;
    logic       hit;
    fe_pc = pc;
    #1;
    idx = pc[9:2] ^ bhr_m;
    bi  = pc[5:2];
    hit = btb_v_m[bi] && (btb_t_m[bi] == pc[31:6]);
    check_val({tag, "_memaddr_pt"}, {24'd0, memaddr_pt}, {24'd0, idx});
    check_val({tag, "_rd_val_pt"}, {30'd0, rd_val_pt}, {30'd0, pt_m[idx]});
    check_val({tag, "_btb_hit"}, {31'd0, btb_hit}, {31'd0, hit});
    check_val({tag, "_pred_taken"}, {31'd0, pred_taken}, {31'd0, hit & pt_m[idx][1] & ~busy_m});
    if (hit) check_val({tag, "_btb_value"}, rd_val_btb_value, btb_d_m[bi]);
  endtask

  task automatic wait_init(input int exp_cycles, input string tag);
    int n;
    n = 0;
    while (busy === 1'b1 && n < 1000) begin
      n++;
      @(posedge clk);
      #1;
    end
    check_val(tag, n, exp_cycles);
    check_val({tag, "_busy_low"}, {31'd0, busy}, 32'd0);
    busy_m = 1'b0;
  endtask

  logic [7:0] bhr_save;

  initial begin
    reset = 1'b1; fe_pc = '0; res_valid = 1'b0; res_is_br = 1'b0; res_is_jmp = 1'b0;
    res_pc = '0; res_pt_idx = '0; res_pred_taken = 1'b0; res_pred_target = '0;
    res_taken = 1'b0; res_target = '0;
    model_reset();
    @(posedge clk);
    #1;
    reset = 1'b0;

    // Initialisation sweep
    wait_init(256, "init_len");
    check_val("rst_bhr", {24'd0, rd_val_bhr}, 32'd0);
    check_val("rst_br_cond", {31'd0, br_cond}, 32'd0);
    check_val("rst_newpc", newpc, 32'd0);
    check_val("rst_br_cnt", br_cnt, 32'd0);
    check_val("rst_mispred_cnt", mispred_cnt, 32'd0);
    lookup_chk(32'h0000_0100, "init_look_a");
    lookup_chk(32'h1234_5678, "init_look_b");
    check_val("init_pt_01", {30'd0, rd_val_pt}, 32'd1);
    check_val("init_no_hit", {31'd0, btb_hit}, 32'd0);

    // Mispredicted taken branch
    fe_pc = 32'h0000_0100;
    resolve(1'b1, 1'b0, 32'h100, 8'h40, 1'b0, 32'h0, 1'b1, 32'h200, "t2");
    check_val("t2_cond_const", {31'd0, br_cond}, 32'd1);
    check_val("t2_newpc_const", newpc, 32'h200);
    check_val("t2_bhr_const", {24'd0, rd_val_bhr}, 32'h01);
    lookup_chk(32'h0000_0104, "t2_pt");
    check_val("t2_pt_const", {30'd0, rd_val_pt}, 32'd2);
    lookup_chk(32'h0000_0100, "t2_btb");
    check_val("t2_hit_const", {31'd0, btb_hit}, 32'd1);
    check_val("t2_value_const", rd_val_btb_value, 32'h200);
    idle_cycle("t2_pulse_end");

    // Counter saturation on idx 0x10
    for (int i = 0; i < 4; i++) begin
      fe_pc = {22'd0, 8'h10 ^ bhr_m, 2'b00};
      resolve(1'b1, 1'b0, 32'h40, 8'h10, 1'b1, 32'h80, 1'b1, 32'h80, $sformatf("t3_tk%0d", i));
      lookup_chk({22'd0, 8'h10 ^ bhr_m, 2'b00}, $sformatf("t3_tk%0d_look", i));
    end
    check_val("t3_sat_hi", {30'd0, rd_val_pt}, 32'd3);
    for (int i = 0; i < 4; i++) begin
      fe_pc = {22'd0, 8'h10 ^ bhr_m, 2'b00};
      resolve(1'b1, 1'b0, 32'h40, 8'h10, 1'b0, 32'h0, 1'b0, 32'h0, $sformatf("t3_nt%0d", i));
      lookup_chk({22'd0, 8'h10 ^ bhr_m, 2'b00}, $sformatf("t3_nt%0d_look", i));
    end
    check_val("t3_sat_lo", {30'd0, rd_val_pt}, 32'd0);
    check_val("t3_bhr_hist", {24'd0, rd_val_bhr}, 32'hF0);

    // Not-taken mispredict at the top of the address space
    resolve(1'b1, 1'b0, 32'hFFFF_FFFC, 8'h22, 1'b1, 32'h0, 1'b0, 32'h0, "t4");
    check_val("t4_newpc_wrap", newpc, 32'h0);
    lookup_chk(32'hFFFF_FFFC, "t4_btb");
    check_val("t4_no_hit", {31'd0, btb_hit}, 32'd0);

    // Back-to-back mispredicts give consecutive pulses
    resolve(1'b1, 1'b0, 32'h500, 8'h05, 1'b0, 32'h0, 1'b1, 32'h600, "t6_a");
    resolve(1'b1, 1'b0, 32'h700, 8'h07, 1'b1, 32'h600, 1'b0, 32'h0, "t6_b");
    idle_cycle("t6_end");

    // Correctly predicted taken branch, then jump with res_is_br also set
    resolve(1'b1, 1'b0, 32'h800, 8'h33, 1'b1, 32'h900, 1'b1, 32'h900, "t5_ok");
    check_val("t5_ok_no_cond", {31'd0, br_cond}, 32'd0);
    bhr_save = bhr_m;
    resolve(1'b1, 1'b1, 32'h300, 8'h55, 1'b1, 32'h340, 1'b1, 32'h340, "t5_jmp");
    check_val("t5_jmp_bhr_kept", {24'd0, rd_val_bhr}, {24'd0, bhr_save});
    lookup_chk({22'd0, 8'h55 ^ bhr_m, 2'b00}, "t5_jmp_pt");
    check_val("t5_jmp_pt_kept", {30'd0, rd_val_pt}, 32'd1);
    lookup_chk(32'h0000_0300, "t5_jmp_btb");
    check_val("t5_jmp_hit", {31'd0, btb_hit}, 32'd1);

    // Reset mid-run, resolutions during INIT are ignored
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    model_reset();
    check_val("rst2_busy", {31'd0, busy}, 32'd1);
    check_val("rst2_bhr", {24'd0, rd_val_bhr}, 32'd0);
    check_val("rst2_br_cnt", br_cnt, 32'd0);
    check_val("rst2_mispred_cnt", mispred_cnt, 32'd0);
    check_val("rst2_br_cond", {31'd0, br_cond}, 32'd0);
    resolve(1'b1, 1'b0, 32'h100, 8'h40, 1'b0, 32'h0, 1'b1, 32'h200, "init_res_a");
    resolve(1'b0, 1'b1, 32'h300, 8'h00, 1'b0, 32'h0, 1'b1, 32'h340, "init_res_b");
    wait_init(254, "init2_len");
    lookup_chk(32'h0000_0100, "rst2_look_a");
    check_val("rst2_pt_01", {30'd0, rd_val_pt}, 32'd1);
    check_val("rst2_no_hit_a", {31'd0, btb_hit}, 32'd0);
    lookup_chk(32'h0000_0300, "rst2_look_b");
    check_val("rst2_no_hit_b", {31'd0, btb_hit}, 32'd0);
    idle_cycle("rst2_idle");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
